multi_io_bias: RTL
==================

# multi_io_bias

Parametrised, multi-channel successor to the single-channel bias stage in the neuron datapath. Captures a vector of `CHANNELS` signed activations on a start pulse, adds a per-channel programmable bias through one shared saturating adder (one channel per cycle), optionally applies ReLU, and signals completion with a one-cycle `ready` pulse. It sits between the weighted-sum accumulator and the next layer's input register.

## Interface

- `WIDTH`, 8: bit width of each activation, bias and result; signed two's complement.
- `CHANNELS`, 4: number of channels per job; must be ≥ 1.
- `AW`, `$clog2(CHANNELS)` (minimum 1): width of the bias address and the channel index.

- `clk`  in  1  sole clock; everything updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `enable`  in  1  start request; sampled only in IDLE.
- `in`  in  `CHANNELS*WIDTH`  input vector; channel k is `in[k*WIDTH +: WIDTH]`.
- `relu_en`  in  1  ReLU mode; captured with `in` at start.
- `bias_we`  in  1  bias register write enable.
- `bias_addr`  in  `AW`  bias register index; writes with index ≥ `CHANNELS` are ignored.
- `bias_wdata`  in  `WIDTH`  bias value (signed).
- `biased_out`  out  `CHANNELS*WIDTH`  result vector, same lane layout as `in`.
- `sat_flags`  out  `CHANNELS`  bit k = 1 if channel k overflowed and was clamped in the last job.
- `busy`  out  1  high in RUN and DONE.
- `ready`  out  1  one-cycle pulse: job complete and outputs valid.

## Operation

- Storage: `CHANNELS` bias registers, input capture register (`CHANNELS*WIDTH`), `relu` capture bit, channel index `idx` (`AW` bits), state register.
- States: IDLE, RUN, DONE.
  - IDLE: when `enable`=1, capture `in` → in_reg, `relu_en` → relu_reg, clear `sat_flags`, set `idx`=0, go to RUN. Otherwise hold.
  - RUN: each cycle compute channel `idx`, write lane `idx` of `biased_out` and bit `idx` of `sat_flags`. If `idx`==`CHANNELS-1`, go to DONE. Otherwise increment `idx`.
  - DONE: `ready`=1 for this cycle only. Go to IDLE unconditionally.
- Arithmetic per channel:
  - sum = sext(in_reg[idx]) + sext(bias[idx]), `WIDTH+1` bits.
  - If sum > 2^(W-1)-1, clamp to max and set the flag. If sum < -2^(W-1), clamp to min and set the flag.
  - If relu_reg and the clamped result is negative, output 0. The saturation flag is kept even when ReLU zeroes the result.
- Bias writes are accepted in every state.
  - A write to the channel being computed in the same cycle takes effect after that edge; the computation uses the old value.
  - Writes in RUN to channels not yet computed are used by the current job.
- `enable` in RUN or DONE is ignored. Changes on `in`/`relu_en` after capture have no effect on the running job.
- `biased_out` lanes update progressively during RUN. The whole vector is valid from the `ready` cycle and is held until lane 0 is rewritten by the next job.

## Timing

- Reset (`rst`=1 at an edge, any state, including mid-job):
  - State goes to IDLE and `idx` to 0.
  - `biased_out`=0, `sat_flags`=0, `busy`=0, `ready`=0.
  - All bias registers and in_reg are cleared to 0.
  - An in-flight job is abandoned with no `ready`.
  - `rst` has priority over `enable` and `bias_we` in the same cycle.
- Latency: `enable` sampled at edge E.
  - RUN occupies cycles E+1 … E+`CHANNELS`.
  - `ready` is high during cycle E+`CHANNELS`+1.
  - Lane k is written at edge E+1+k.
- Throughput: the next `enable` is accepted no earlier than the edge ending the DONE cycle, giving one job per `CHANNELS`+2 cycles.
- `ready` and `busy` are decoded from the registered state, so they are glitch-free and never high during IDLE.
- `CHANNELS`=1: RUN lasts one cycle; `ready` occurs at E+2.

## Test plan

- Reset then basic job (W=8, C=4):
  - Stimulus: biases {5,5,5,5}, `in`={5,10,-3,0}, `relu_en`=0, `enable` for 1 cycle.
  - Required: `ready` exactly 4+1 cycles after the start edge; `biased_out`={10,15,2,5}; `sat_flags`=0.
- Saturation:
  - Stimulus: biases {100,-100,127,-128}, `in`={100,-100,1,-1}.
  - Required: outputs {127,-128,127,-128}; `sat_flags`=4'b1111.
- ReLU:
  - Stimulus: biases {-10,10,0,-128}, `in`={5,-20,0,-10}, `relu_en`=1.
  - Required: outputs {0,0,0,0}; `sat_flags`=4'b1000.
- Ignored restart and bias write during RUN:
  - Stimulus: pulse `enable` again in RUN with a different `in`; in the same cycle lane 1 is computed, write bias[1]=50 and bias[3]=50.
  - Required: a single `ready`; lane 1 uses the old bias and lane 3 uses 50; the next job's lane 1 uses 50.
- Mid-job reset:
  - Stimulus: assert `rst` for 1 cycle two cycles after start.
  - Required: no `ready`; all outputs 0 the following cycle.
  - Then a new job with biases reprogrammed gives correct results.
- Back-to-back jobs:
  - Stimulus: `enable` held high continuously.
  - Required: `ready` pulses every 6 cycles; `busy` low exactly one cycle between jobs.

Source files
------------

// File: rtl/multi_io_bias.sv
// Multi-channel bias stage: captures a vector of signed activations, adds a
// programmable per-channel bias through one shared saturating adder, optional ReLU.
module multi_io_bias #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int AW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic [CHANNELS*WIDTH-1:0] in,
  input  logic                      relu_en,
  input  logic                      bias_we,
  input  logic [AW-1:0]             bias_addr,
  input  logic [WIDTH-1:0]          bias_wdata,
  output logic [CHANNELS*WIDTH-1:0] biased_out,
  output logic [CHANNELS-1:0]       sat_flags,
  output logic                      busy,
  output logic                      ready
);

  localparam logic [AW-1:0] LAST_IDX = AW'(CHANNELS - 1);
  localparam logic signed [WIDTH-1:0] MAX_VAL = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [AW-1:0]             idx_q;
  logic [CHANNELS*WIDTH-1:0] in_q;
  logic [CHANNELS*WIDTH-1:0] out_q;
  logic [CHANNELS-1:0]       sat_q;
  logic                      relu_q;
  logic [WIDTH-1:0]          bias_q [CHANNELS];

  logic [31:0]              lane_base;
  logic signed [WIDTH-1:0]  lane_in;
  logic signed [WIDTH-1:0]  lane_bias;
  logic signed [WIDTH:0]    lane_sum;
  logic signed [WIDTH-1:0]  lane_res;
  logic                     lane_sat;

  // Shared adder: overflow shows up as disagreement between the two top bits
  // of the sign-extended sum; the top bit then tells which rail to clamp to.
  always_comb begin
    lane_base = 32'(idx_q) * WIDTH;
    lane_in   = in_q[lane_base +: WIDTH];
    lane_bias = bias_q[idx_q];
    lane_sum  = {lane_in[WIDTH-1], lane_in} + {lane_bias[WIDTH-1], lane_bias};
    lane_sat  = lane_sum[WIDTH] != lane_sum[WIDTH-1];
    if (!lane_sat) begin
      lane_res = lane_sum[WIDTH-1:0];
    end else if (lane_sum[WIDTH]) begin
      lane_res = MIN_VAL;
    end else begin
      lane_res = MAX_VAL;
    end
    if (relu_q && lane_res[WIDTH-1]) begin
      lane_res = '0;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (enable) state_d = RUN;
      RUN:     if (idx_q == LAST_IDX) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Results are not cleared at job start; each lane holds until it is recomputed.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_q   <= '0;
      relu_q <= 1'b0;
      idx_q  <= '0;
      out_q  <= '0;
      sat_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (enable) begin
            in_q   <= in;
            relu_q <= relu_en;
            sat_q  <= '0;
            idx_q  <= '0;
          end
        end
        RUN: begin
          out_q[lane_base +: WIDTH] <= lane_res;
          sat_q[idx_q]              <= lane_sat;
          if (idx_q != LAST_IDX) begin
            idx_q <= idx_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Addresses beyond the last channel match no register and are dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < CHANNELS; k++) begin
        bias_q[k] <= '0;
      end
    end else if (bias_we) begin
      for (int k = 0; k < CHANNELS; k++) begin
        if (bias_addr == AW'(k)) begin
          bias_q[k] <= bias_wdata;
        end
      end
    end
  end

  assign biased_out = out_q;
  assign sat_flags  = sat_q;
  assign busy       = (state_q != IDLE);
  assign ready      = (state_q == DONE);

endmodule
